// File: rtl/output_frame_scheduler.sv
// Frame/column sequencer between the double buffer and the LED output path.
// Optional: OUTPUT_FRAME_SCHEDULER_AUTO_REFRESH_EN re-sends the last image every frame period.
module output_frame_scheduler #(
    parameter int COLUMN_COUNT          = 16,
    parameter int FRAME_PERIOD_CYCLES   = 450000,
    parameter int COLUMN_TIMEOUT_CYCLES = 65535,
    parameter int LATCH_CYCLES          = 4
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_enable,
    input  logic                          I_buffer_updated,
    input  logic                          I_image_valid,
    input  logic                          I_tx_finish,
    input  logic                          I_clear_error,
    output logic                          O_next_image,
    output logic                          O_next_column,
    output logic [$clog2(COLUMN_COUNT):0] O_column_index,
    output logic                          O_buffer_lock,
    output logic                          O_busy,
    output logic                          O_timeout_error,
    output logic [15:0]                   O_frame_count
);

    localparam int IW = $clog2(COLUMN_COUNT) + 1;
    localparam int FP = (FRAME_PERIOD_CYCLES < 1) ? 1 : FRAME_PERIOD_CYCLES;
    localparam int TC = (COLUMN_TIMEOUT_CYCLES < 1) ? 1 : COLUMN_TIMEOUT_CYCLES;
    localparam int LC = (LATCH_CYCLES < 1) ? 1 : LATCH_CYCLES;
    localparam int PW = (FP > 1) ? $clog2(FP) : 1;
    localparam int TW = (TC > 1) ? $clog2(TC) : 1;
    localparam int LW = (LC > 1) ? $clog2(LC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FSTART,
        S_CSTART,
        S_CWAIT,
        S_LATCH
    } state_e;

    state_e          state_q, state_d;
    logic            pend_q, pend_d;
    logic [PW-1:0]   per_q, per_d;
    logic [IW-1:0]   col_q, col_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;

    logic            period_ok;
    logic            start_req;
    logic            last_col;
    logic            tmo_hit;
    logic            lat_done;
    logic            go_start;
    logic            tmo_event;

    assign period_ok = (per_q == '0);
    assign last_col  = (col_q == IW'(COLUMN_COUNT - 1));
    assign tmo_hit   = (tmo_q == TW'(TC - 1));
    assign lat_done  = (lat_q == LW'(LC - 1));

`ifdef OUTPUT_FRAME_SCHEDULER_AUTO_REFRESH_EN
    assign start_req = period_ok & (pend_q | I_image_valid);
`else
    assign start_req = period_ok & pend_q;
`endif

    assign go_start  = (state_q == S_WAIT) && (state_d == S_FSTART);
    assign tmo_event = (state_q == S_CWAIT) && !I_tx_finish && tmo_hit;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (I_enable && I_image_valid) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!I_enable || !I_image_valid) state_d = S_IDLE;
                else if (start_req)              state_d = S_FSTART;
            end
            S_FSTART: state_d = S_CSTART;
            S_CSTART: state_d = S_CWAIT;
            S_CWAIT: begin
                // a finish in the timeout cycle still counts as a clean column
                if (I_tx_finish)  state_d = last_col ? S_LATCH : S_CSTART;
                else if (tmo_hit) state_d = S_LATCH;
            end
            S_LATCH: begin
                if (lat_done) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pend_d = I_buffer_updated | (pend_q & (state_q != S_FSTART));

        per_d = period_ok ? per_q : per_q - PW'(1);
        if (go_start) per_d = PW'(FP - 1);

        col_d = col_q;
        if (state_q == S_FSTART) col_d = '0;
        else if (state_q == S_CWAIT && I_tx_finish && !last_col)
            col_d = col_q + IW'(1);

        tmo_d = tmo_q;
        if (state_q == S_CSTART)     tmo_d = '0;
        else if (state_q == S_CWAIT) tmo_d = tmo_q + TW'(1);

        lat_d = (state_q == S_LATCH) ? lat_q + LW'(1) : '0;

        err_d = tmo_event | (err_q & ~I_clear_error);

        cnt_d = cnt_q;
        if (state_q == S_LATCH && lat_done) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            pend_q <= 1'b0;
            per_q  <= '0;
            col_q  <= '0;
            tmo_q  <= '0;
            lat_q  <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            per_q  <= per_d;
            col_q  <= col_d;
            tmo_q  <= tmo_d;
            lat_q  <= lat_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        O_next_image  = (state_q == S_FSTART);
        O_next_column = (state_q == S_CSTART);
        O_buffer_lock = (state_q == S_FSTART) || (state_q == S_CSTART) ||
                        (state_q == S_CWAIT)  || (state_q == S_LATCH);
        O_busy        = (state_q != S_IDLE);
    end

    assign O_column_index  = col_q;
    assign O_timeout_error = err_q;
    assign O_frame_count   = cnt_q;

endmodule

// File: doc/output_frame_scheduler.md
Name: output_frame_scheduler

Overview:
Sequences frame transmission from the double buffer to the LED matrix in the sys_clk_27MHz domain. Starts a frame on a buffer update or refresh tick, then steps column by column through the output path, waiting for each column's transfer to finish. Holds a swap-inhibit lock while a frame is in flight and flags stalled columns with a timeout. Sits between Matrix_Buffer's O_buffer_updated and the Output_Logic/Output_Module next_image/next_column/tx_finish handshake.

Parameters:
COLUMN_COUNT, 16, columns per frame; must be ≥1.
FRAME_PERIOD_CYCLES, 450000, minimum cycles between frame starts (60 Hz at 27 MHz).
COLUMN_TIMEOUT_CYCLES, 65535, maximum cycles to wait for I_tx_finish per column.
LATCH_CYCLES, 4, idle cycles after the last column before the frame completes (output latch settle).

Ports:
I_clk  in  1  system clock (sys_clk_27MHz).
I_rst_n  in  1  asynchronous active-low reset.
I_enable  in  1  scheduler enable; level.
I_buffer_updated  in  1  one-cycle pulse: new image available in the read bank.
I_image_valid  in  1  read-side image dimensions are valid.
I_tx_finish  in  1  one-cycle pulse: current column transfer complete.
I_clear_error  in  1  one-cycle pulse: clears O_timeout_error.
O_next_image  out  1  one-cycle pulse at frame start.
O_next_column  out  1  one-cycle pulse per column start.
O_column_index  out  $clog2(COLUMN_COUNT)+1  index of the active column.
O_buffer_lock  out  1  high from frame start to frame end; inhibits bank swap.
O_busy  out  1  high in any state except IDLE.
O_timeout_error  out  1  sticky column-timeout flag.
O_frame_count  out  16  frames completed, wraps at 2^16.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; pending flag and all counters cleared. An asynchronous reset mid-frame aborts immediately, with no closing pulse.
- Pending flag: set by I_buffer_updated in any state, including mid-frame. Cleared on the cycle O_next_image is issued. A pulse arriving in that same cycle keeps the flag set (set wins).
- Period counter: free-running. Reloads to FRAME_PERIOD_CYCLES-1 at each O_next_image and saturates at 0. Frame start is allowed only when the counter is 0.
- IDLE: if I_enable=1 and I_image_valid=1, go to WAIT.
- WAIT: if I_enable=0 or I_image_valid=0, go to IDLE. If pending=1 and the period counter is 0, go to FRAME_START.
- FRAME_START (1 cycle): O_next_image=1; O_buffer_lock=1 from this cycle on; column index set to 0; go to COL_START.
- COL_START (1 cycle): O_next_column=1; O_column_index holds the current index; timeout counter cleared; go to COL_WAIT.
- COL_WAIT:
  - On I_tx_finish: if index = COLUMN_COUNT-1, go to LATCH; else increment the index and go to COL_START.
  - If the timeout counter reaches COLUMN_TIMEOUT_CYCLES: set O_timeout_error and go to LATCH (the frame is abandoned).
  - I_tx_finish in the same cycle as the timeout: finish wins, no error.
- I_tx_finish is ignored outside COL_WAIT.
- LATCH: wait LATCH_CYCLES cycles. Then increment O_frame_count, drop O_buffer_lock, and go to WAIT.
- I_enable deasserted mid-frame: the current frame completes normally; the FSM goes to IDLE from WAIT.
- O_timeout_error: cleared only by I_clear_error or reset. I_clear_error and a new timeout in the same cycle: set wins.
- Latency: a buffer_updated pulse in WAIT with the counter at 0 gives O_next_image 2 cycles later (flag registered, then state). O_next_column follows O_next_image by 1 cycle.
- Minimum column gap: I_tx_finish to the next O_next_column is 1 cycle.

Optional Feature:
Macro OUTPUT_FRAME_SCHEDULER_AUTO_REFRESH_EN.
- Defined: in WAIT, a frame also starts with pending=0 once the period counter reaches 0 and I_image_valid=1. The last image is re-sent at FRAME_PERIOD_CYCLES to keep the matrix refreshed.
- Undefined: frames start only on pending=1; the matrix holds its last image.

Test Plan:
- Reset, enable=1, image_valid=1, one I_buffer_updated pulse; I_tx_finish 10 cycles after each O_next_column, COLUMN_COUNT=4 -> O_next_image once, 4 O_next_column with index 0,1,2,3; lock high throughout; O_frame_count=1.
- Two I_buffer_updated pulses during a frame, FRAME_PERIOD_CYCLES=100 -> second frame starts exactly 100 cycles after the first O_next_image; one extra frame only; O_frame_count=2.
- Withhold I_tx_finish on column 2, COLUMN_TIMEOUT_CYCLES=50 -> O_timeout_error=1 after 50 cycles; LATCH; lock released; I_clear_error clears the flag.
- Async reset asserted in COL_WAIT -> all outputs 0 immediately; no O_next_image until a new I_buffer_updated pulse after release.
- With AUTO_REFRESH_EN defined, one update, FRAME_PERIOD_CYCLES=200 -> O_next_image at t0, t0+200, t0+400. Without the macro -> a single frame only.
- I_tx_finish and the timeout in the same cycle -> no error; column index advances.
